traffic_phase_sequencer: RTL and testbench

Controller for the two-road traffic signal on the Nexys 3 board. Sequences the six signal phases (NS green/yellow, all-red, EW green/yellow, all-red), owns the per-phase countdown that drives the single-digit 7-segment display, shortens the active green on a pedestrian request, and supports a flashing-yellow override. It sits between the 1 Hz tick generator and the LED/7-segment drivers, and replaces free-running countdown use with a phase-loaded countdown.

---
 rtl/traffic_phase_sequencer_if.sv | 24 ++
 rtl/traffic_phase_sequencer.sv | 144 ++++++++++++++
 tb/tb_traffic_phase_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_phase_sequencer_if.sv
// Signal bundle between the traffic controller and its environment
// (tick source, pedestrian button, flash switch, LED and 7-segment drivers).
interface traffic_phase_sequencer_if;
  logic       tick;
  logic       ped_req;
  logic       flash;
  logic [2:0] ns_lights;
  logic [2:0] ew_lights;
  logic [3:0] count;
  logic [2:0] phase;
  logic       ped_ack;

  // Environment side: drives the requests, observes the lights/display.
  modport master (
    output tick, ped_req, flash,
    input  ns_lights, ew_lights, count, phase, ped_ack
  );

  // Controller side.
  modport slave (
    input  tick, ped_req, flash,
    output ns_lights, ew_lights, count, phase, ped_ack
  );
endinterface

// File: rtl/traffic_phase_sequencer.sv
// Two-road traffic signal phase sequencer with per-phase countdown,
// pedestrian green shortening and flashing-yellow override.
// All outputs are registered; lights are decoded from the next state so
// they change on the same edge as the phase.
module traffic_phase_sequencer #(
  parameter int GREEN_SEC  = 9,
  parameter int YELLOW_SEC = 3,
  parameter int ALLRED_SEC = 1,
  parameter int PED_MIN    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  traffic_phase_sequencer_if.slave    bus
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_A = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_B = 3'd5,
    FLASH     = 3'd6
  } phase_t;

  localparam logic [3:0] GREEN_LEN  = 4'(GREEN_SEC);
  localparam logic [3:0] YELLOW_LEN = 4'(YELLOW_SEC);
  localparam logic [3:0] ALLRED_LEN = 4'(ALLRED_SEC);
  localparam logic [3:0] PED_LEN    = 4'(PED_MIN);

  phase_t     state, state_d;
  logic [3:0] count, count_d;
  logic       latch, latch_d;
  logic       blink, blink_d;
  logic       ack_d, ped_ack_q;
  logic [2:0] ns_q, ew_q, ns_d, ew_d;

  function automatic phase_t next_phase(input phase_t s);
    case (s)
      NS_GREEN:  return NS_YELLOW;
      NS_YELLOW: return ALL_RED_A;
      ALL_RED_A: return EW_GREEN;
      EW_GREEN:  return EW_YELLOW;
      EW_YELLOW: return ALL_RED_B;
      ALL_RED_B: return NS_GREEN;
      default:   return ALL_RED_B;
    endcase
  endfunction

  function automatic logic [3:0] phase_len(input phase_t s);
    case (s)
      NS_GREEN, EW_GREEN:   return GREEN_LEN;
      NS_YELLOW, EW_YELLOW: return YELLOW_LEN;
      default:              return ALLRED_LEN;
    endcase
  endfunction

  // Next-state logic: flash override first, then tick-driven sequencing.
  always_comb begin
    state_d = state;
    count_d = count;
    blink_d = blink;
    latch_d = latch | bus.ped_req;
    ack_d   = 1'b0;
    if (bus.flash) begin
      latch_d = 1'b0;
      if (state != FLASH) begin
        state_d = FLASH;
        count_d = '0;
        blink_d = 1'b1;
      end else if (bus.tick) begin
        blink_d = ~blink;
      end
    end else if (state == FLASH) begin
      state_d = ALL_RED_B;
      count_d = ALLRED_LEN;
      blink_d = 1'b0;
      latch_d = 1'b0;
    end else if (state > ALL_RED_B) begin
      state_d = ALL_RED_B;
      count_d = ALLRED_LEN;
    end else if (bus.tick) begin
      if (count == 4'd1) begin
        state_d = next_phase(state);
        count_d = phase_len(state_d);
        if (state_d == NS_YELLOW || state_d == EW_YELLOW) begin
          // A request arriving on the clearing edge re-arms the latch.
          ack_d   = latch;
          latch_d = bus.ped_req;
        end
      end else if ((state == NS_GREEN || state == EW_GREEN) && latch
                   && count > PED_LEN) begin
        count_d = PED_LEN;
      end else begin
        count_d = count - 4'd1;
      end
    end
  end

  // Light decode of the upcoming phase, registered alongside it.
  always_comb begin
    ns_d = 3'b100;
    ew_d = 3'b100;
    case (state_d)
      NS_GREEN:  ns_d = 3'b001;
      NS_YELLOW: ns_d = 3'b010;
      EW_GREEN:  ew_d = 3'b001;
      EW_YELLOW: ew_d = 3'b010;
      FLASH: begin
        ns_d = {1'b0, blink_d, 1'b0};
        ew_d = {1'b0, blink_d, 1'b0};
      end
      default: ;
    endcase
  end

  // State, countdown, latch and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ALL_RED_B;
      count     <= ALLRED_LEN;
      latch     <= 1'b0;
      blink     <= 1'b0;
      ped_ack_q <= 1'b0;
      ns_q      <= 3'b100;
      ew_q      <= 3'b100;
    end else begin
      state     <= state_d;
      count     <= count_d;
      latch     <= latch_d;
      blink     <= blink_d;
      ped_ack_q <= ack_d;
      ns_q      <= ns_d;
      ew_q      <= ew_d;
    end
  end

  assign bus.phase     = state;
  assign bus.count     = count;
  assign bus.ped_ack   = ped_ack_q;
  assign bus.ns_lights = ns_q;
  assign bus.ew_lights = ew_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Bench for traffic_phase_sequencer: a behavioural model pushes expected
// outputs per clock into a queue; a monitor pops and compares after each edge.
module tb_traffic_phase_sequencer;

  localparam int GS = 9;
  localparam int YS = 3;
  localparam int AS = 1;
  localparam int PM = 2;

  typedef struct packed {
    logic [2:0] phase;
    logic [3:0] count;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       ack;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  traffic_phase_sequencer_if bus ();

  traffic_phase_sequencer #(
    .GREEN_SEC (GS),
    .YELLOW_SEC(YS),
    .ALLRED_SEC(AS),
    .PED_MIN   (PM)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Model state
  int   m_phase, m_count;
  bit   m_latch, m_blink, m_ack;
  obs_t exp_q[$];

  function automatic int dur(input int ph);
    case (ph)
      0, 3:    return GS;
      1, 4:    return YS;
      default: return AS;
    endcase
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.phase = 3'(m_phase);
    o.count = 4'(m_count);
    o.ack   = m_ack;
    case (m_phase)
      0: begin o.ns = 3'b001; o.ew = 3'b100; end
      1: begin o.ns = 3'b010; o.ew = 3'b100; end
      3: begin o.ns = 3'b100; o.ew = 3'b001; end
      4: begin o.ns = 3'b100; o.ew = 3'b010; end
      6: begin o.ns = {1'b0, m_blink, 1'b0}; o.ew = {1'b0, m_blink, 1'b0}; end
      default: begin o.ns = 3'b100; o.ew = 3'b100; end
    endcase
    return o;
  endfunction

  task automatic model_reset();
    m_phase = 5; m_count = AS; m_latch = 0; m_blink = 0; m_ack = 0;
  endtask

  task automatic model_edge(input bit t, input bit p, input bit f);
    bit nl;
    m_ack = 0;
    if (!rst_n) begin
      model_reset();
    end else if (f) begin
      if (m_phase != 6) begin m_phase = 6; m_count = 0; m_blink = 1; end
      else if (t) m_blink = !m_blink;
      m_latch = 0;
    end else if (m_phase == 6) begin
      m_phase = 5; m_count = AS; m_blink = 0; m_latch = 0;
    end else begin
      nl = m_latch | p;
      if (t) begin
        if (m_count == 1) begin
          m_phase = (m_phase + 1) % 6;
          m_count = dur(m_phase);
          if (m_phase == 1 || m_phase == 4) begin
            m_ack = m_latch;
            nl = p;
          end
        end else if ((m_phase == 0 || m_phase == 3) && m_latch && m_count > PM) begin
          m_count = PM;
        end else begin
          m_count = m_count - 1;
        end
      end
      m_latch = nl;
    end
  endtask

  // One clock: drive inputs on the falling edge, record the expectation,
  // return shortly after the rising edge once the monitor has compared.
  task automatic step(input bit t, input bit p, input bit f);
    @(negedge clk);
    bus.tick = t; bus.ped_req = p; bus.flash = f;
    model_edge(t, p, f);
    exp_q.push_back(model_obs());
    @(posedge clk);
    #2;
  endtask

  task automatic do_tick(input bit p);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0); step(1, p, 0);
  endtask

  task automatic run_to(input int ph, input int cnt);
    int n = 0;
    while (!(m_phase == ph && m_count == cnt) && n < 100) begin
      do_tick(0);
      n++;
    end
    total++;
    if (n >= 100) begin
      bad++;
      $display("FAIL run_to: phase/count %0d/%0d not reached, model at %0d/%0d", ph, cnt, m_phase, m_count);
    end
  endtask

  // Scoreboard monitor
  always @(posedge clk) begin
    obs_t a, e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.phase = bus.phase; a.count = bus.count; a.ns = bus.ns_lights;
      a.ew = bus.ew_lights; a.ack = bus.ped_ack;
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL scoreboard t=%0t: got ph=%0d cnt=%0d ns=%b ew=%b ack=%b want ph=%0d cnt=%0d ns=%b ew=%b ack=%b",
                 $time, a.phase, a.count, a.ns, a.ew, a.ack, e.phase, e.count, e.ns, e.ew, e.ack);
      end
    end
  end

  task automatic test_reset();
    bus.tick = 0; bus.ped_req = 0; bus.flash = 0;
    model_reset();
    step(1, 0, 0); step(1, 1, 0);
    total++;
    if ({bus.phase, bus.count, bus.ns_lights, bus.ew_lights, bus.ped_ack} !==
        {3'd5, 4'(AS), 3'b100, 3'b100, 1'b0}) begin
      bad++;
      $display("FAIL reset_values: got ph=%0d cnt=%0d ns=%b ew=%b ack=%b", bus.phase, bus.count,
               bus.ns_lights, bus.ew_lights, bus.ped_ack);
    end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_cycle();
    logic [2:0] ns_tab [6];
    logic [2:0] ew_tab [6];
    ns_tab = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    ew_tab = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
    do_tick(0);
    for (int unsigned i = 0; i < 6; i++) begin
      total++;
      if (bus.phase !== 3'(i) || bus.count !== 4'(dur(i)) || bus.ns_lights !== ns_tab[i]
          || bus.ew_lights !== ew_tab[i]) begin
        bad++;
        $display("FAIL cycle_entry%0d: got ph=%0d cnt=%0d ns=%b ew=%b want ph=%0d cnt=%0d ns=%b ew=%b",
                 i, bus.phase, bus.count, bus.ns_lights, bus.ew_lights, i, dur(i), ns_tab[i], ew_tab[i]);
      end
      for (int k = dur(i) - 1; k >= 1; k--) begin
        do_tick(0);
        total++;
        if (bus.count !== 4'(k)) begin
          bad++;
          $display("FAIL cycle_count%0d: got %0d want %0d", i, bus.count, k);
        end
      end
      do_tick(0);
    end
  endtask

  task automatic test_ped_shorten();
    run_to(0, 7);
    step(0, 1, 0);
    do_tick(0);
    total++;
    if (bus.count !== 4'(PM)) begin
      bad++; $display("FAIL ped_shorten: count got %0d want %0d", bus.count, PM);
    end
    do_tick(0);
    do_tick(0);
    total++;
    if (bus.phase !== 3'd1 || bus.ped_ack !== 1'b1) begin
      bad++; $display("FAIL ped_ack_pulse: got ph=%0d ack=%b want ph=1 ack=1", bus.phase, bus.ped_ack);
    end
    step(0, 0, 0);
    total++;
    if (bus.ped_ack !== 1'b0) begin
      bad++; $display("FAIL ped_ack_width: ack got %b want 0", bus.ped_ack);
    end
  endtask

  task automatic test_ped_no_shorten();
    run_to(0, 2);
    step(0, 1, 0);
    do_tick(0);
    total++;
    if (bus.count !== 4'd1) begin
      bad++; $display("FAIL ped_at_min: count got %0d want 1", bus.count);
    end
    do_tick(0);
    total++;
    if (bus.ped_ack !== 1'b1) begin
      bad++; $display("FAIL ped_at_min_ack: ack got %b want 1", bus.ped_ack);
    end
    run_to(2, 1);
    step(0, 1, 0);
    do_tick(0);
    do_tick(0);
    total++;
    if (bus.phase !== 3'd3 || bus.count !== 4'(PM)) begin
      bad++; $display("FAIL ped_allred: got ph=%0d cnt=%0d want ph=3 cnt=%0d", bus.phase, bus.count, PM);
    end
  endtask

  task automatic test_flash();
    run_to(3, 5);
    step(0, 1, 0);
    step(0, 0, 1);
    total++;
    if (bus.phase !== 3'd6 || bus.count !== 4'd0 || bus.ns_lights !== 3'b010
        || bus.ew_lights !== 3'b010 || bus.ped_ack !== 1'b0) begin
      bad++;
      $display("FAIL flash_entry: got ph=%0d cnt=%0d ns=%b ew=%b ack=%b", bus.phase, bus.count,
               bus.ns_lights, bus.ew_lights, bus.ped_ack);
    end
    step(1, 0, 1);
    total++;
    if (bus.ns_lights !== 3'b000 || bus.ew_lights !== 3'b000) begin
      bad++; $display("FAIL flash_blink: got ns=%b ew=%b want 000", bus.ns_lights, bus.ew_lights);
    end
    step(1, 1, 1); step(0, 0, 1);
    step(0, 0, 0);
    total++;
    if (bus.phase !== 3'd5 || bus.count !== 4'(AS)) begin
      bad++; $display("FAIL flash_exit: got ph=%0d cnt=%0d want ph=5 cnt=%0d", bus.phase, bus.count, AS);
    end
    do_tick(0);
    do_tick(0);
    total++;
    if (bus.phase !== 3'd0 || bus.count !== 4'(GS - 1)) begin
      bad++; $display("FAIL flash_latch_clear: got ph=%0d cnt=%0d want ph=0 cnt=%0d", bus.phase, bus.count, GS - 1);
    end
    // flash and tick together on a normal-phase edge: flash wins
    step(1, 0, 1);
    step(0, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_to(3, 1);
    step(0, 1, 0);
    step(0, 0, 0); step(0, 0, 0);
    step(1, 1, 0);
    total++;
    if (bus.phase !== 3'd4 || bus.ped_ack !== 1'b1) begin
      bad++; $display("FAIL b2b_ack: got ph=%0d ack=%b want ph=4 ack=1", bus.phase, bus.ped_ack);
    end
    run_to(0, GS);
    do_tick(0);
    total++;
    if (bus.count !== 4'(PM)) begin
      bad++; $display("FAIL b2b_relatch: count got %0d want %0d", bus.count, PM);
    end
  endtask

  task automatic test_async_reset();
    run_to(4, 2);
    step(0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.phase, bus.count, bus.ns_lights, bus.ew_lights, bus.ped_ack} !==
        {3'd5, 4'(AS), 3'b100, 3'b100, 1'b0}) begin
      bad++;
      $display("FAIL async_reset: got ph=%0d cnt=%0d ns=%b ew=%b ack=%b", bus.phase, bus.count,
               bus.ns_lights, bus.ew_lights, bus.ped_ack);
    end
    model_reset();
    step(1, 0, 0);
    #1 rst_n = 1'b1;
    do_tick(0);
    total++;
    if (bus.phase !== 3'd0 || bus.count !== 4'(GS)) begin
      bad++; $display("FAIL restart: got ph=%0d cnt=%0d want ph=0 cnt=%0d", bus.phase, bus.count, GS);
    end
  endtask

  initial begin
    test_reset();
    test_cycle();
    test_ped_shorten();
    test_ped_no_shorten();
    test_flash();
    test_back_to_back();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
